elastic_join_fu: RTL and testbench

//  Two-operand functional unit stage of the CGRA processing element.

---
 rtl/elastic_join_fu.sv | 110 +++++++++++
 tb/tb_elastic_join_fu.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_join_fu.sv
// Two-operand join + ALU stage with optional reduction; FU_MUL_EN adds a combinational multiplier for op 8.
// Latency 1 cycle from join to dout_v_o; operands stall only when the result must be emitted into a full, unready slot.
module elastic_join_fu #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [3:0]            op_i,
    input  logic                  acc_en_i,
    input  logic [CNT_WIDTH-1:0]  acc_len_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic                  a_v_i,
    output logic                  a_r_o,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  b_v_i,
    output logic                  b_r_o,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  dout_v_o,
    input  logic                  dout_r_i
);
    localparam int SH_W = $clog2(DATA_WIDTH);

    typedef enum logic {ACCUM, LAST} red_state_t;

    red_state_t            state;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, last_idx;
    logic [DATA_WIDTH-1:0] acc_q, acc_d, dout_d, alu_r, sum;
    logic                  dout_v_d, slot_free, emit, gate, join_ok;
    logic [SH_W-1:0]       shamt;

    assign shamt = b_i[SH_W-1:0];

    always_comb begin
        alu_r = '0;
        case (op_i)
            4'd0:    alu_r = a_i + b_i;
            4'd1:    alu_r = a_i - b_i;
            4'd2:    alu_r = a_i & b_i;
            4'd3:    alu_r = a_i | b_i;
            4'd4:    alu_r = a_i ^ b_i;
            4'd5:    alu_r = a_i << shamt;
            4'd6:    alu_r = a_i >> shamt;
            4'd7:    alu_r = $signed(a_i) >>> shamt;
`ifdef FU_MUL_EN
            4'd8:    alu_r = a_i * b_i;
`else
            4'd8:    alu_r = '0;
`endif
            4'd9:    alu_r = a_i;
            4'd10:   alu_r = b_i;
            4'd11:   alu_r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: alu_r = '0;
        endcase
    end

    // A reduction length of 0 behaves like 1: every join is the last one.
    assign last_idx  = (acc_len_i == '0) ? '0 : acc_len_i - CNT_WIDTH'(1);
    assign state     = (!acc_en_i || cnt_q == last_idx) ? LAST : ACCUM;
    assign emit      = (state == LAST);
    assign slot_free = !dout_v_o || dout_r_i;
    assign gate      = en_i && !clr_i && (emit ? slot_free : 1'b1);
    assign a_r_o     = gate && b_v_i;
    assign b_r_o     = gate && a_v_i;
    assign join_ok   = gate && a_v_i && b_v_i;
    assign sum       = (cnt_q == '0) ? alu_r : acc_q + alu_r;

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dout_d   = dout_o;
        dout_v_d = dout_v_o;
        if (en_i) begin
            if (clr_i) begin
                cnt_d    = '0;
                acc_d    = '0;
                dout_v_d = 1'b0;
            end else begin
                if (dout_v_o && dout_r_i) dout_v_d = 1'b0;
                if (join_ok) begin
                    if (emit) begin
                        dout_d   = sum;
                        dout_v_d = 1'b1;
                        cnt_d    = '0;
                        acc_d    = '0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            dout_o   <= '0;
            dout_v_o <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            dout_o   <= dout_d;
            dout_v_o <= dout_v_d;
        end
    end
endmodule

// File: tb/tb_elastic_join_fu.sv
// Scenario bench for elastic_join_fu: a reference model pushes expected results on each operand handshake,
// and the output monitor pops and compares them on each result transfer.
module tb_elastic_join_fu;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b1, clr_i = 1'b0;
    logic [3:0]  op_i = 4'd0;
    logic        acc_en_i = 1'b0;
    logic [15:0] acc_len_i = 16'd0;
    logic [31:0] a_i = '0, b_i = '0;
    logic        a_v_i = 1'b0, b_v_i = 1'b0;
    logic        a_r_o, b_r_o;
    logic [31:0] dout_o;
    logic        dout_v_o;
    logic        dout_r_i = 1'b0;

    int checks = 0, errors = 0, out_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_acc = '0;
    int          m_cnt = 0;

`ifdef FU_MUL_EN
    localparam logic [31:0] MUL_EXP = 32'd21;
`else
    localparam logic [31:0] MUL_EXP = 32'd0;
`endif

    elastic_join_fu #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i), .op_i(op_i),
        .acc_en_i(acc_en_i), .acc_len_i(acc_len_i),
        .a_i(a_i), .a_v_i(a_v_i), .a_r_o(a_r_o),
        .b_i(b_i), .b_v_i(b_v_i), .b_r_o(b_r_o),
        .dout_o(dout_o), .dout_v_o(dout_v_o), .dout_r_i(dout_r_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return $unsigned($signed(a) >>> sh);
            4'd8:  return MUL_EXP == 32'd0 ? 32'd0 : a * b;
            4'd9:  return a;
            4'd10: return b;
            4'd11: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Scoreboard: compare drained results first, then account for this cycle's handshake.
    always @(negedge clk_i) begin
        logic [31:0] r, s, e;
        int len;
        if (rst_i) begin
            exp_q.delete(); m_cnt = 0; m_acc = '0;
        end else if (en_i) begin
            if (clr_i) begin
                exp_q.delete(); m_cnt = 0; m_acc = '0;
            end else begin
                if (dout_v_o && dout_r_i) begin
                    checks++; out_cnt++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: got dout=%h with nothing expected", dout_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (dout_o !== e) begin
                            errors++;
                            $display("FAIL sb_data: got %h expected %h", dout_o, e);
                        end
                    end
                end
                if (a_v_i && a_r_o && b_v_i && b_r_o) begin
                    r   = model(op_i, a_i, b_i);
                    s   = (m_cnt == 0) ? r : m_acc + r;
                    len = (acc_len_i == 0) ? 1 : int'(acc_len_i);
                    if (!acc_en_i || m_cnt == len - 1) begin
                        exp_q.push_back(s); m_cnt = 0; m_acc = '0;
                    end else begin
                        m_acc = s; m_cnt++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic v);
        a_i = a; b_i = b; a_v_i = v; b_v_i = v;
    endtask

    task automatic test_reset();
        tick(); tick(); #1;
        checks++;
        if (dout_v_o !== 1'b0 || dout_o !== 32'd0 || a_r_o !== 1'b0 || b_r_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got v=%b d=%h ar=%b br=%b expected 0 0 0 0", dout_v_o, dout_o, a_r_o, b_r_o);
        end
        rst_i = 1'b0;
        tick(); #1;
        checks++;
        if (dout_v_o !== 1'b0 || dout_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_release: got v=%b d=%h expected 0 0", dout_v_o, dout_o);
        end
    endtask

    task automatic test_add_stream();
        int start;
        start = out_cnt; op_i = 4'd0; acc_en_i = 1'b0; dout_r_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(); drive(i, 32'd10, 1'b1); #1;
            checks++;
            if (a_r_o !== 1'b1 || b_r_o !== 1'b1) begin
                errors++;
                $display("FAIL add_ready i=%0d: got ar=%b br=%b expected 1 1", i, a_r_o, b_r_o);
            end
            if (i > 1) begin
                checks++;
                if (dout_v_o !== 1'b1 || dout_o !== 32'(9 + i)) begin
                    errors++;
                    $display("FAIL add_latency i=%0d: got v=%b d=%0d expected 1 %0d", i, dout_v_o, dout_o, 9 + i);
                end
            end
        end
        tick(); drive(0, 0, 1'b0); #1;
        checks++;
        if (dout_o !== 32'd18) begin
            errors++;
            $display("FAIL add_last: got %0d expected 18", dout_o);
        end
        tick(); tick();
        checks++;
        if (out_cnt - start != 8) begin
            errors++;
            $display("FAIL add_count: got %0d outputs expected 8", out_cnt - start);
        end
    endtask

    task automatic test_backpressure();
        tick(); dout_r_i = 1'b0; drive(5, 6, 1'b1);
        tick(); drive(7, 1, 1'b1); #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (a_r_o !== 1'b0 || b_r_o !== 1'b0 || dout_v_o !== 1'b1 || dout_o !== 32'd11) begin
                errors++;
                $display("FAIL bp_stall k=%0d: got ar=%b br=%b v=%b d=%0d expected 0 0 1 11", k, a_r_o, b_r_o, dout_v_o, dout_o);
            end
            tick();
        end
        dout_r_i = 1'b1; #1;
        checks++;
        if (a_r_o !== 1'b1 || b_r_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got ar=%b br=%b expected 1 1", a_r_o, b_r_o);
        end
        tick(); drive(0, 0, 1'b0); #1;
        checks++;
        if (dout_v_o !== 1'b1 || dout_o !== 32'd8) begin
            errors++;
            $display("FAIL bp_reload: got v=%b d=%0d expected 1 8", dout_v_o, dout_o);
        end
        tick(); #1;
        checks++;
        if (dout_v_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got v=%b expected 0", dout_v_o);
        end
    endtask

    task automatic test_join_skew();
        tick(); op_i = 4'd0; a_i = 32'd100; a_v_i = 1'b1; b_v_i = 1'b0; #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (a_r_o !== 1'b0 || b_r_o !== 1'b1 || dout_v_o !== 1'b0) begin
                errors++;
                $display("FAIL skew_wait k=%0d: got ar=%b br=%b v=%b expected 0 1 0", k, a_r_o, b_r_o, dout_v_o);
            end
            tick();
        end
        b_i = 32'd23; b_v_i = 1'b1; #1;
        checks++;
        if (a_r_o !== 1'b1 || b_r_o !== 1'b1) begin
            errors++;
            $display("FAIL skew_join: got ar=%b br=%b expected 1 1", a_r_o, b_r_o);
        end
        tick(); drive(0, 0, 1'b0); #1;
        checks++;
        if (dout_v_o !== 1'b1 || dout_o !== 32'd123) begin
            errors++;
            $display("FAIL skew_result: got v=%b d=%0d expected 1 123", dout_v_o, dout_o);
        end
        tick();
    endtask

    task automatic test_reduction();
        int start;
        start = out_cnt; op_i = 4'd0; acc_en_i = 1'b1; acc_len_i = 16'd4; dout_r_i = 1'b0;
        // Two back-to-back reductions with the first result left stalled in the output slot.
        for (int i = 1; i <= 8; i++) begin
            tick(); drive(i, 0, 1'b1); #1;
            checks++;
            if (a_r_o !== (i != 8) || b_r_o !== (i != 8)) begin
                errors++;
                $display("FAIL red_ready i=%0d: got ar=%b br=%b expected %b", i, a_r_o, b_r_o, (i != 8));
            end
        end
        checks++;
        if (dout_v_o !== 1'b1 || dout_o !== 32'd10) begin
            errors++;
            $display("FAIL red_first: got v=%b d=%0d expected 1 10", dout_v_o, dout_o);
        end
        tick(); dout_r_i = 1'b1;
        tick(); drive(0, 0, 1'b0); #1;
        checks++;
        if (dout_v_o !== 1'b1 || dout_o !== 32'd26) begin
            errors++;
            $display("FAIL red_second: got v=%b d=%0d expected 1 26", dout_v_o, dout_o);
        end
        tick(); tick();
        checks++;
        if (out_cnt - start != 2) begin
            errors++;
            $display("FAIL red_count: got %0d outputs expected 2", out_cnt - start);
        end
    endtask

    task automatic test_len_zero();
        int start;
        start = out_cnt; acc_en_i = 1'b1; acc_len_i = 16'd0; dout_r_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick(); drive(2 * i, 1, 1'b1); #1;
            if (i > 1) begin
                checks++;
                if (dout_v_o !== 1'b1 || dout_o !== 32'(2 * i - 1)) begin
                    errors++;
                    $display("FAIL len0_emit i=%0d: got v=%b d=%0d expected 1 %0d", i, dout_v_o, dout_o, 2 * i - 1);
                end
            end
        end
        tick(); drive(0, 0, 1'b0); tick(); tick();
        checks++;
        if (out_cnt - start != 3) begin
            errors++;
            $display("FAIL len0_count: got %0d outputs expected 3", out_cnt - start);
        end
    endtask

    task automatic test_clear();
        acc_en_i = 1'b1; acc_len_i = 16'd4; dout_r_i = 1'b1; op_i = 4'd0;
        tick(); drive(100, 0, 1'b1);
        tick(); drive(200, 0, 1'b1);
        tick(); drive(999, 0, 1'b1); clr_i = 1'b1; #1;
        checks++;
        if (a_r_o !== 1'b0 || b_r_o !== 1'b0) begin
            errors++;
            $display("FAIL clr_ready: got ar=%b br=%b expected 0 0", a_r_o, b_r_o);
        end
        tick(); clr_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(i, 0, 1'b1); tick();
        end
        drive(0, 0, 1'b0); #1;
        checks++;
        if (dout_v_o !== 1'b1 || dout_o !== 32'd10) begin
            errors++;
            $display("FAIL clr_result: got v=%b d=%0d expected 1 10", dout_v_o, dout_o);
        end
        tick();
    endtask

    task automatic test_ops();
        typedef struct packed { logic [3:0] op; logic [31:0] a, b, e; } vec_t;
        vec_t v[14];
        v[0]  = '{4'd1,  32'd10,         32'd3,          32'd7};
        v[1]  = '{4'd2,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000};
        v[2]  = '{4'd3,  32'h0000_0F00,  32'h0000_00F0,  32'h0000_0FF0};
        v[3]  = '{4'd4,  32'h0000_FFFF,  32'h0000_0F0F,  32'h0000_F0F0};
        v[4]  = '{4'd5,  32'd1,          32'd36,         32'd16};
        v[5]  = '{4'd6,  32'h8000_0000,  32'd4,          32'h0800_0000};
        v[6]  = '{4'd7,  32'h8000_0000,  32'd4,          32'hF800_0000};
        v[7]  = '{4'd8,  32'd3,          32'd7,          MUL_EXP};
        v[8]  = '{4'd9,  32'h1234,       32'h5678,       32'h1234};
        v[9]  = '{4'd10, 32'h1234,       32'h5678,       32'h5678};
        v[10] = '{4'd11, 32'hFFFF_FFFF,  32'd1,          32'd1};
        v[11] = '{4'd11, 32'd1,          32'hFFFF_FFFF,  32'd0};
        v[12] = '{4'd13, 32'd55,         32'd66,         32'd0};
        v[13] = '{4'd0,  32'hFFFF_FFFF,  32'd2,          32'd1};
        acc_en_i = 1'b0; dout_r_i = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick(); op_i = v[i].op; drive(v[i].a, v[i].b, 1'b1);
            tick(); drive(0, 0, 1'b0); #1;
            checks++;
            if (dout_v_o !== 1'b1 || dout_o !== v[i].e) begin
                errors++;
                $display("FAIL op%0d vec%0d: got v=%b d=%h expected 1 %h", v[i].op, i, dout_v_o, dout_o, v[i].e);
            end
        end
        tick();
    endtask

    task automatic test_enable();
        op_i = 4'd0; acc_en_i = 1'b0;
        tick(); dout_r_i = 1'b0; drive(40, 2, 1'b1);
        tick(); en_i = 1'b0; dout_r_i = 1'b1; drive(1, 1, 1'b1); #1;
        checks++;
        if (a_r_o !== 1'b0 || b_r_o !== 1'b0) begin
            errors++;
            $display("FAIL en_ready: got ar=%b br=%b expected 0 0", a_r_o, b_r_o);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (dout_v_o !== 1'b1 || dout_o !== 32'd42) begin
                errors++;
                $display("FAIL en_hold k=%0d: got v=%b d=%0d expected 1 42", k, dout_v_o, dout_o);
            end
        end
        drive(0, 0, 1'b0); en_i = 1'b1;
        tick(); #1;
        checks++;
        if (dout_v_o !== 1'b0) begin
            errors++;
            $display("FAIL en_drain: got v=%b expected 0", dout_v_o);
        end
    endtask

    task automatic test_reset_mid();
        op_i = 4'd0; acc_en_i = 1'b0;
        tick(); dout_r_i = 1'b0; drive(9, 9, 1'b1);
        tick(); acc_en_i = 1'b1; acc_len_i = 16'd4; drive(5, 0, 1'b1);
        tick(); drive(0, 0, 1'b0); rst_i = 1'b1; #1;
        checks++;
        if (dout_v_o !== 1'b0 || dout_o !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid: got v=%b d=%h expected 0 0", dout_v_o, dout_o);
        end
        tick(); rst_i = 1'b0; acc_len_i = 16'd2; dout_r_i = 1'b1;
        tick(); drive(3, 0, 1'b1);
        tick(); drive(4, 0, 1'b1);
        tick(); drive(0, 0, 1'b0); #1;
        checks++;
        if (dout_v_o !== 1'b1 || dout_o !== 32'd7) begin
            errors++;
            $display("FAIL rst_cnt_zero: got v=%b d=%0d expected 1 7", dout_v_o, dout_o);
        end
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_add_stream();
        test_backpressure();
        test_join_skew();
        test_reduction();
        test_len_zero();
        test_clear();
        test_ops();
        test_enable();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending results expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
